// File: rtl/pip_reg_ctrl_pkg.sv
// Shared definitions for the elastic pipeline register: width helper for the
// occupancy counter.
package pip_reg_ctrl_pkg;

    // Bits needed to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pip_reg_ctrl_if.sv
// Handshake bundle for pip_reg_ctrl: upstream valid/ready, downstream valid/ready,
// synchronous flush and occupancy count.
interface pip_reg_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
);
    // A beat moves on a side only in a cycle where valid and ready are both high
    // at the clock edge; valid must not wait for ready, and ready may depend
    // combinationally on the far side's ready (out_ready -> in_ready).
    logic                                       flush;
    logic                                       in_valid;
    logic                                       in_ready;
    logic [WIDTH-1:0]                           in;
    logic                                       out_valid;
    logic                                       out_ready;
    logic [WIDTH-1:0]                           out;
    logic [pip_reg_ctrl_pkg::cnt_w(DEPTH)-1:0]  count;

    modport master (
        output flush, in_valid, in, out_ready,
        input  in_ready, out_valid, out, count
    );

    modport slave (
        input  flush, in_valid, in, out_ready,
        output in_ready, out_valid, out, count
    );

endinterface

// File: rtl/pip_reg_stage.sv
// One stage of the elastic pipeline: a data word plus its valid bit, loading from
// its source whenever the stage is allowed to advance.
module pip_reg_stage #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             adv,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (adv) begin
                valid <= src_valid;
            end
            // Data only moves with a real item, and a flush leaves it untouched.
            if (adv && src_valid && !flush) begin
                data <= src_data;
            end
        end
    end

endmodule

// File: rtl/pip_reg_ctrl.sv
// Elastic pipeline register: DEPTH stages with bubble collapsing, stall via
// out_ready and kill via flush.
module pip_reg_ctrl
    import pip_reg_ctrl_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic           clk,
    input logic           rst,
    pip_reg_ctrl_if.slave bus
);

    localparam int CNT_W = cnt_w(DEPTH);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] src_valid;
    logic [WIDTH-1:0] data     [DEPTH];
    logic [WIDTH-1:0] src_data [DEPTH];
    logic             adv_acc;
    logic [CNT_W-1:0] cnt;

    // A stage may advance if downstream drains or any stage at or after it is empty.
    always_comb begin
        adv_acc = bus.out_ready;
        adv     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv_acc = adv_acc | !valid[i];
            adv[i]  = adv_acc;
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + CNT_W'(valid[i]);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign src_valid[i] = bus.in_valid & bus.in_ready;
            assign src_data[i]  = bus.in;
        end else begin : g_body
            assign src_valid[i] = valid[i-1];
            assign src_data[i]  = data[i-1];
        end

        pip_reg_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (bus.flush),
            .adv       (adv[i]),
            .src_valid (src_valid[i]),
            .src_data  (src_data[i]),
            .valid     (valid[i]),
            .data      (data[i])
        );
    end

    assign bus.in_ready  = adv[0] & !bus.flush;
    assign bus.out_valid = valid[DEPTH-1];
    assign bus.out       = data[DEPTH-1];
    assign bus.count     = cnt;

endmodule

// File: tb/tb_pip_reg_ctrl.sv
// Directed bench for pip_reg_ctrl: three instances (DEPTH 3/2/1) covering reset,
// streaming, stall, bubble collapse, flush and plain-register behaviour.
module tb_pip_reg_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pip_reg_ctrl_if #(.WIDTH(32), .DEPTH(3)) bus3 ();
    pip_reg_ctrl_if #(.WIDTH(32), .DEPTH(2)) bus2 ();
    pip_reg_ctrl_if #(.WIDTH(32), .DEPTH(1)) bus1 ();

    pip_reg_ctrl #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'hDEADBEEF)) dut3 (
        .clk (clk), .rst (rst), .bus (bus3)
    );
    pip_reg_ctrl #(.WIDTH(32), .DEPTH(2), .RESET_VAL(32'h0)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );
    pip_reg_ctrl #(.WIDTH(32), .DEPTH(1), .RESET_VAL(32'h0)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] stream [5];
        logic [31:0] plain  [6];
        stream = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h00000000, 32'h12345678};
        plain  = '{32'h00000001, 32'h80000000, 32'h13579BDF, 32'h2468ACE0, 32'h0F0F0F0F, 32'hFFFF0000};

        bus3.flush = 0; bus3.in_valid = 0; bus3.in = 0; bus3.out_ready = 0;
        bus2.flush = 0; bus2.in_valid = 0; bus2.in = 0; bus2.out_ready = 0;
        bus1.flush = 0; bus1.in_valid = 0; bus1.in = 0; bus1.out_ready = 0;

        // Reset state
        step();
        step();
        check("rst_out",       bus3.out, 32'hDEADBEEF);
        check("rst_out_valid", 32'(bus3.out_valid), 32'd0);
        check("rst_count",     32'(bus3.count), 32'd0);
        check("rst_in_ready",  32'(bus3.in_ready), 32'd1);
        rst = 0;
        step();

        // Streaming through DEPTH=3, out_ready high
        bus3.out_ready = 1;
        for (int k = 0; k < 7; k++) begin
            bus3.in_valid = (k < 5);
            bus3.in       = (k < 5) ? stream[k] : 32'h0;
            step();
            if (k == 4) check("stream_full_count", 32'(bus3.count), 32'd3);
            if (k >= 2) begin
                check("stream_out_valid", 32'(bus3.out_valid), 32'd1);
                check("stream_out",       bus3.out, stream[k-2]);
            end
        end
        bus3.in_valid = 0;
        step();
        check("stream_drain_valid", 32'(bus3.out_valid), 32'd0);
        check("stream_drain_count", 32'(bus3.count), 32'd0);

        // Asynchronous reset mid-stream
        bus3.in_valid = 1; bus3.in = 32'h11223344; bus3.out_ready = 0;
        step();
        bus3.in = 32'h55667788;
        step();
        check("pre_rst_count", 32'(bus3.count), 32'd2);
        #3;
        rst = 1;
        #1;
        check("async_rst_out",       bus3.out, 32'hDEADBEEF);
        check("async_rst_out_valid", 32'(bus3.out_valid), 32'd0);
        check("async_rst_count",     32'(bus3.count), 32'd0);
        check("async_rst_in_ready",  32'(bus3.in_ready), 32'd1);
        step();
        rst = 0;
        bus3.in_valid = 0; bus3.in = 0;
        step();
        check("post_rst_count", 32'(bus3.count), 32'd0);

        // Stall on DEPTH=2
        bus2.out_ready = 0;
        bus2.in_valid  = 1; bus2.in = 32'h11111111;
        step();
        bus2.in = 32'h22222222;
        step();
        bus2.in = 32'h33333333;
        #1;
        check("stall_in_ready_full", 32'(bus2.in_ready), 32'd0);
        for (int c = 0; c < 4; c++) begin
            step();
            check("stall_count",    32'(bus2.count), 32'd2);
            check("stall_out",      bus2.out, 32'h11111111);
            check("stall_in_ready", 32'(bus2.in_ready), 32'd0);
        end
        bus2.in_valid  = 0;
        bus2.out_ready = 1;
        #1;
        check("release_in_ready_comb", 32'(bus2.in_ready), 32'd1);
        check("release_out_first",     bus2.out, 32'h11111111);
        step();
        check("release_out_second", bus2.out, 32'h22222222);
        check("release_valid",      32'(bus2.out_valid), 32'd1);
        check("release_count",      32'(bus2.count), 32'd1);
        step();
        check("release_empty", 32'(bus2.count), 32'd0);

        // Bubble collapse on DEPTH=3 with downstream stalled
        bus3.out_ready = 0;
        bus3.in_valid  = 1; bus3.in = 32'h0000ABCD;
        #1;
        check("bubble_in_ready0", 32'(bus3.in_ready), 32'd1);
        step();
        bus3.in_valid = 0; bus3.in = 0;
        #1;
        check("bubble_e1_count",    32'(bus3.count), 32'd1);
        check("bubble_e1_in_ready", 32'(bus3.in_ready), 32'd1);
        check("bubble_e1_valid",    32'(bus3.out_valid), 32'd0);
        step();
        check("bubble_e2_in_ready", 32'(bus3.in_ready), 32'd1);
        check("bubble_e2_valid",    32'(bus3.out_valid), 32'd0);
        step();
        check("bubble_e3_valid",    32'(bus3.out_valid), 32'd1);
        check("bubble_e3_out",      bus3.out, 32'h0000ABCD);
        check("bubble_e3_count",    32'(bus3.count), 32'd1);
        check("bubble_e3_in_ready", 32'(bus3.in_ready), 32'd1);
        step();
        check("bubble_hold_out", bus3.out, 32'h0000ABCD);

        // Fill remaining stages, then flush with an input on offer
        bus3.in_valid = 1; bus3.in = 32'h00000001;
        step();
        bus3.in = 32'h00000002;
        step();
        bus3.in_valid = 0;
        #1;
        check("flush_pre_count",    32'(bus3.count), 32'd3);
        check("flush_pre_in_ready", 32'(bus3.in_ready), 32'd0);
        bus3.flush = 1; bus3.in_valid = 1; bus3.in = 32'hCAFEF00D; bus3.out_ready = 1;
        #1;
        check("flush_in_ready", 32'(bus3.in_ready), 32'd0);
        step();
        bus3.flush = 0; bus3.in_valid = 0; bus3.in = 0;
        #1;
        check("flush_count",     32'(bus3.count), 32'd0);
        check("flush_out_valid", 32'(bus3.out_valid), 32'd0);
        check("flush_data_kept", bus3.out, 32'h0000ABCD);
        for (int c = 0; c < 3; c++) begin
            step();
            check("flush_no_cafe_valid", 32'(bus3.out_valid), 32'd0);
            check("flush_no_cafe_out",   bus3.out, 32'h0000ABCD);
        end

        // DEPTH=1 behaves as a plain register
        bus1.out_ready = 1;
        bus1.in_valid  = 1;
        for (int k = 0; k < 6; k++) begin
            bus1.in = plain[k];
            step();
            check("plain_out",       bus1.out, plain[k]);
            check("plain_out_valid", 32'(bus1.out_valid), 32'd1);
            check("plain_in_ready",  32'(bus1.in_ready), 32'd1);
        end
        bus1.in_valid = 0;
        step();
        check("plain_idle_valid", 32'(bus1.out_valid), 32'd0);
        check("plain_idle_out",   bus1.out, 32'hFFFF0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pip_reg_ctrl.md
# pip_reg_ctrl

Parametrised elastic pipeline register: a chain of DEPTH stages, each WIDTH bits wide, with a per-stage valid bit, valid/ready handshakes on both sides, bubble collapsing, synchronous flush and asynchronous reset. It replaces the plain always-load pipeline register between processor stages (IF/ID, ID/EX, EX/MEM, MEM/WB), so hazard logic can stall with out_ready and kill with flush.

## Interface
- WIDTH, 32: payload width in bits (≥1).
- DEPTH, 1: number of register stages (≥1).
- RESET_VAL, 0: value loaded into every data stage on reset (WIDTH bits).
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill: all valid bits cleared at next edge.
- in_valid  in  1  upstream offers in.
- in_ready  out  1  block accepts in this cycle.
- in  in  WIDTH  input payload.
- out_valid  out  1  valid bit of last stage.
- out_ready  in  1  downstream accepts out this cycle (low = stall).
- out  out  WIDTH  data of last stage.
- count  out  $clog2(DEPTH+1)  number of valid stages.

## Operation
- State: data[i] (WIDTH), valid[i], i = 0..DEPTH-1; stage DEPTH-1 drives out/out_valid.
- Advance: adv[DEPTH-1] = out_ready | !valid[DEPTH-1]; adv[i] = adv[i+1] | !valid[i]. Empty stages always advance (bubble collapse).
- in_ready = adv[0] & !flush.
- At an edge, for each stage with adv[i]: valid[i] ← source valid (in_valid & in_ready for stage 0, valid[i-1] otherwise); data[i] ← source data only when source valid, else retained. Stages without adv[i] hold both.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- flush: all valid[i] ← 0 at the edge; data unchanged; in_ready forced 0 so no input is taken. An output transfer in the flush cycle still counts as delivered.
- count: popcount of valid[]; 0..DEPTH, never exceeds DEPTH.
- No reordering, duplication or loss except by flush.

## Timing
- Reset (async assert, any time, including mid-transfer): valid[] = 0, data[] = RESET_VAL, so out = RESET_VAL, out_valid = 0, count = 0, in_ready = 1 (flush low). Release takes effect at the next edge.
- Latency: item accepted at edge k into empty pipe has out_valid high after edge k+DEPTH-1... i.e. visible on out DEPTH cycles after the input was presented.
- Throughput: 1 item/cycle with out_ready held high, any DEPTH.
- DEPTH=1, in_valid=1, out_ready=1: identical to a plain pipeline register (out follows in one cycle later).
- Full, out_ready=0: in_ready=0, all stages hold.
- Full, out_ready=1: in_ready=1 same cycle (combinational out_ready→in_ready path; documented, not registered).
- Flush and rst together: rst wins.
- Flush with out_ready=0: contents discarded, no output transfer.

## Structure
- Shared pipeline package: CNT_W-style width helper for count ($clog2(DEPTH+1)); no typedefs required.
- One sub-module: pip_reg_stage (single stage: data + valid, inputs adv, src_valid, src_data, flush, clk, rst), instantiated DEPTH times by generate loop; adv chain and count in top level.

## Test plan
- Reset: rst=1 mid-stream with RESET_VAL=32'hDEADBEEF → out=32'hDEADBEEF, out_valid=0, count=0 immediately, before next edge.
- Streaming, DEPTH=3, out_ready=1: inputs A5A5A5A5, 5A5A5A5A, FFFFFFFF, 00000000, 12345678 on consecutive cycles → same sequence on out starting 3 cycles later, no gaps.
- Stall: DEPTH=2, fill with 11111111, 22222222, out_ready=0 for 4 cycles → in_ready=0, count=2, out=11111111 held; release → 11111111 then 22222222.
- Bubble collapse: DEPTH=3, one item 0000ABCD, then in_valid=0, out_ready=0 → item reaches last stage after 3 edges, count=1, in_ready stays 1 while 2 stages empty.
- Flush: DEPTH=3 full, flush=1 with in_valid=1, in=CAFEF00D → next cycle count=0, out_valid=0, CAFEF00D never appears on out.
- DEPTH=1 regression: previous plain-register sequence with out_ready=1 → out identical to old register output cycle-for-cycle.
